data_stack: RTL and testbench
=============================

# data_stack

Data stack of the stack processor, sitting directly downstream of the control decoder. It consumes the decoder's `stackOP` and `stackControl` fields plus the instruction immediate, ALU result, memory read data and input-port data. It maintains a LIFO of 16-bit words and exposes the top two entries (`top`, `next`) to the ALU, memory and branch logic. Underflow and overflow are detected, the offending operation is blocked, and a sticky flag is raised.

## Interface
- `WIDTH`, 16, data word width.
- `DEPTH`, 16, maximum number of entries (≥2).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears the stack.
- `en`  in  1  operation enable; 0 = hold everything (driven by PCWrite; stalls on halt).
- `stackOP`  in  3  0 hold, 1 push, 2 pop2-push1 (binary op), 3 pop, 4 pop2, 5 swap, 6–7 hold.
- `stackControl`  in  3  push-source select: 0 imm sign-extended, 1 lui, 2 memData, 3 aluResult, 4 inData, 5–7 zero.
- `imm`  in  12  instruction bits [11:0].
- `aluResult`  in  WIDTH  ALU output.
- `memData`  in  WIDTH  data-memory read data.
- `inData`  in  WIDTH  input-port value.
- `top`  out  WIDTH  entry at depth 1; 0 when count==0.
- `next`  out  WIDTH  entry at depth 2; 0 when count<2.
- `count`  out  $clog2(DEPTH+1)  current number of entries.
- `underflow`  out  1  sticky; set when an op needs more entries than are present.
- `overflow`  out  1  sticky; set when a net-growing op is issued while full.

## Operation
- Source mux (combinational): `src` = {{4{imm[11]}}, imm} for 0; {imm[7:0], 8'h00} for 1; memData for 2; aluResult for 3; inData for 4; 0 otherwise.
- Ops, applied on the clock edge when `en`=1:
  - push (1): requires count<DEPTH; new top=src; old top becomes next; count+1.
  - binary (2): requires count≥2; removes top and next; pushes src; count−1.
  - pop (3): requires count≥1; count−1.
  - pop2 (4): requires count≥2; count−2.
  - swap (5): requires count≥2; exchanges top and next; count unchanged.
  - hold (0, 6, 7): no change, no flag.
- Requirement violated: the stack is left fully unchanged. A push when count==DEPTH sets `overflow`. Any other shortfall sets `underflow`. Flags clear only on `reset`.
- `top`/`next` are registered. Entries 3..DEPTH live in an internal array. Values popped below the visible pair reappear intact on later pops.
- Read-before-write: `src` may depend on current `top`/`next` via `aluResult` (dup, over, add). The new value is computed from pre-edge contents.
- Deep entries are never cleared on pop. Outputs mask stale data by `count`.

## Timing
- Reset (synchronous, edge with `reset`=1): count=0, top=0, next=0, underflow=0, overflow=0. `reset` overrides `en` and `stackOP`.
- All state updates take effect at the same rising edge. Results are visible on outputs immediately after, with 1-cycle latency from op presentation.
- `en`=0: zero state change, including flags, regardless of `stackOP`.
- Reset asserted mid-sequence discards all contents. The first op after reset sees an empty stack.
- No combinational path from `stackOP`/sources to `top`/`next`/`count`. Flags are registered.
- Push at count==DEPTH−1 succeeds (count=DEPTH). The next push overflows. A pop at count==DEPTH then allows a push again.

## Test plan
- Reset, then push imm=0x005 (src 0), push imm=0xFFE (src 0) -> top=0xFFFE, next=0x0005, count=2, flags 0.
- With stack 0x0007, 0x0003 (top=0x0003), binary op with aluResult=0x000A -> top=0x000A, next=0 (count=1). Then lui imm=0x012 push -> top=0x1200, next=0x000A.
- Push 1..5 via aluResult, swap -> top=4, next=5. pop2 -> top=3, next=2, count=3. Three pops -> count=0, top=0. Fourth pop -> underflow=1, count stays 0.
- Fill to DEPTH=16 with values 0x0100+i. Push 0xBEEF -> overflow=1, count=16, top=0x010F. Pop 15 times -> top=0x0100 (deep entries preserved).
- Count=1: swap, binary op, and pop2 each -> underflow=1, top unchanged. `en`=0 with push of memData=0x1234 -> no change.
- Mid-sequence reset with count=5 and both flags set -> all outputs 0 next cycle. Push inData=0x00AA -> top=0x00AA, count=1.

Source files
------------

// File: rtl/data_stack.sv
// -----------------------------------------------------------------------------
// data_stack
//
// Data stack of the stack processor. It sits directly after the control
// decoder and holds a LIFO of WIDTH-bit words. The top two entries are kept in
// dedicated registers (top, next) so the ALU, memory and branch logic see them
// with no array read in the path. Entries at depth 3..DEPTH live in an
// internal array that is indexed by absolute position from the bottom of the
// stack.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high; empties the stack, clears flags
//   en            in   operation enable; 0 freezes all state, including flags
//   stackOP       in   0 hold, 1 push, 2 pop2-push1, 3 pop, 4 pop2, 5 swap,
//                      6/7 hold
//   stackControl  in   push source: 0 imm sign-extended, 1 lui, 2 memData,
//                      3 aluResult, 4 inData, 5..7 zero
//   imm           in   instruction immediate bits [11:0]
//   aluResult     in   ALU output
//   memData       in   data-memory read data
//   inData        in   input-port value
//   top           out  entry at depth 1 (0 when the stack is empty)
//   next          out  entry at depth 2 (0 when fewer than two entries)
//   count         out  number of entries currently on the stack
//   underflow     out  sticky; an op needed more entries than were present
//   overflow      out  sticky; a push was issued while the stack was full
//
// Handshake: there is no valid/ready pair. An operation is presented on
// stackOP/stackControl/sources while en=1 and is applied on that rising edge;
// its result is visible on top/next/count/flags right after the edge. An op
// whose entry requirement is not met leaves the stack untouched and only
// raises the matching sticky flag.
// -----------------------------------------------------------------------------
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   stackOP,
    input  logic [2:0]                   stackControl,
    input  logic [11:0]                  imm,
    input  logic [WIDTH-1:0]             aluResult,
    input  logic [WIDTH-1:0]             memData,
    input  logic [WIDTH-1:0]             inData,
    output logic [WIDTH-1:0]             top,
    output logic [WIDTH-1:0]             next,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         underflow,
    output logic                         overflow
);

    // -------------------------------------------------------------------------
    // Local parameters
    // -------------------------------------------------------------------------
    localparam int CW = $clog2(DEPTH + 1);

    // The deep array holds positions 0..DEPTH-3. Keep at least one word so a
    // DEPTH=2 build still elaborates; in that case it is never written.
    localparam int DEEP_N = (DEPTH > 2) ? (DEPTH - 2) : 1;
    localparam int AW     = (DEEP_N > 1) ? $clog2(DEEP_N) : 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);
    localparam logic [CW-1:0] THREE_C = CW'(3);
    localparam logic [CW-1:0] FOUR_C  = CW'(4);

    // Operation codes from the decoder.
    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_BINARY = 3'd2;
    localparam logic [2:0] OP_POP    = 3'd3;
    localparam logic [2:0] OP_POP2   = 3'd4;
    localparam logic [2:0] OP_SWAP   = 3'd5;

    // Push-source codes.
    localparam logic [2:0] SRC_IMM = 3'd0;
    localparam logic [2:0] SRC_LUI = 3'd1;
    localparam logic [2:0] SRC_MEM = 3'd2;
    localparam logic [2:0] SRC_ALU = 3'd3;
    localparam logic [2:0] SRC_IN  = 3'd4;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] top_q;
    logic [WIDTH-1:0] next_q;
    logic [CW-1:0]    count_q;
    logic             underflow_q;
    logic             overflow_q;
    logic [WIDTH-1:0] deep [DEEP_N];

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] top_d;
    logic [WIDTH-1:0] next_d;
    logic [CW-1:0]    count_d;
    logic             underflow_set;
    logic             overflow_set;
    logic             deep_we;
    logic [AW-1:0]    deep_waddr;
    logic [WIDTH-1:0] deep_wdata;

    // Deep reads: the entry that moves up into `next` (depth 3) and, for pop2,
    // the one below it (depth 4). Positions count-3 and count-4 from bottom.
    logic [AW-1:0]    rd_idx3;
    logic [AW-1:0]    rd_idx4;
    logic [WIDTH-1:0] depth3;
    logic [WIDTH-1:0] depth4;

    // -------------------------------------------------------------------------
    // Push-source mux
    // -------------------------------------------------------------------------
    always_comb begin
        src = '0;
        case (stackControl)
            SRC_IMM: src = {{(WIDTH-12){imm[11]}}, imm};
            SRC_LUI: src = {imm[7:0], {(WIDTH-8){1'b0}}};
            SRC_MEM: src = memData;
            SRC_ALU: src = aluResult;
            SRC_IN:  src = inData;
            default: src = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Deep-array read ports
    // -------------------------------------------------------------------------
    // A slot that is emptied is loaded with zero instead of stale array
    // contents, which keeps top/next at 0 whenever count is too small and lets
    // the outputs come straight from registers.
    always_comb begin
        rd_idx3 = AW'(count_q - THREE_C);
        rd_idx4 = AW'(count_q - FOUR_C);
        depth3  = (count_q >= THREE_C) ? deep[rd_idx3] : '0;
        depth4  = (count_q >= FOUR_C)  ? deep[rd_idx4] : '0;
    end

    // -------------------------------------------------------------------------
    // Operation decode
    // -------------------------------------------------------------------------
    // Every value below comes from pre-edge state (top_q/next_q/deep) plus the
    // source mux, so an aluResult that itself depends on top/next (dup, over,
    // add) is consumed correctly in the same cycle.
    always_comb begin
        top_d         = top_q;
        next_d        = next_q;
        count_d       = count_q;
        underflow_set = 1'b0;
        overflow_set  = 1'b0;
        deep_we       = 1'b0;
        deep_waddr    = AW'(count_q - TWO_C);
        deep_wdata    = next_q;

        if (en) begin
            case (stackOP)
                OP_PUSH: begin
                    if (count_q == DEPTH_C) begin
                        overflow_set = 1'b1;
                    end else begin
                        top_d   = src;
                        next_d  = top_q;
                        count_d = count_q + ONE_C;
                        // Old next sinks into the array only if it was real.
                        deep_we = (count_q >= TWO_C);
                    end
                end

                OP_BINARY: begin
                    if (count_q < TWO_C) begin
                        underflow_set = 1'b1;
                    end else begin
                        top_d   = src;
                        next_d  = depth3;
                        count_d = count_q - ONE_C;
                    end
                end

                OP_POP: begin
                    if (count_q < ONE_C) begin
                        underflow_set = 1'b1;
                    end else begin
                        top_d   = next_q;
                        next_d  = depth3;
                        count_d = count_q - ONE_C;
                    end
                end

                OP_POP2: begin
                    if (count_q < TWO_C) begin
                        underflow_set = 1'b1;
                    end else begin
                        top_d   = depth3;
                        next_d  = depth4;
                        count_d = count_q - TWO_C;
                    end
                end

                OP_SWAP: begin
                    if (count_q < TWO_C) begin
                        underflow_set = 1'b1;
                    end else begin
                        top_d  = next_q;
                        next_d = top_q;
                    end
                end

                default: begin
                    // OP_HOLD and the unused codes 6/7: no change, no flag.
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Visible registers and flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q       <= '0;
            next_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            top_q       <= top_d;
            next_q      <= next_d;
            count_q     <= count_d;
            underflow_q <= underflow_q | underflow_set;
            overflow_q  <= overflow_q  | overflow_set;
        end
    end

    // -------------------------------------------------------------------------
    // Deep storage
    // -------------------------------------------------------------------------
    // Not reset and never cleared on pop: count alone decides which words are
    // live, and popped words below the visible pair stay intact for later pops.
    always_ff @(posedge clk) begin
        if (!reset && deep_we) begin
            deep[deep_waddr] <= deep_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign top       = top_q;
    assign next      = next_q;
    assign count     = count_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_data_stack.sv
// -----------------------------------------------------------------------------
// tb_data_stack
//
// Drives data_stack with the directed sequences from the block's test plan,
// then with randomized operations. A queue-based reference stack predicts the
// post-edge state for every presented operation; a monitor compares the DUT
// outputs after each rising edge.
// -----------------------------------------------------------------------------
module tb_data_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = 2 * WIDTH + CW + 2;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       stackOP;
    logic [2:0]       stackControl;
    logic [11:0]      imm;
    logic [WIDTH-1:0] aluResult;
    logic [WIDTH-1:0] memData;
    logic [WIDTH-1:0] inData;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    count;
    logic             underflow;
    logic             overflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .stackOP      (stackOP),
        .stackControl (stackControl),
        .imm          (imm),
        .aluResult    (aluResult),
        .memData      (memData),
        .inData       (inData),
        .top          (top),
        .next         (next),
        .count        (count),
        .underflow    (underflow),
        .overflow     (overflow)
    );

    // -------------------------------------------------------------------------
    // Reference model: a plain queue, last element is the top of stack
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] stk [$];
    logic             m_uf;
    logic             m_of;

    function automatic logic [WIDTH-1:0] m_top();
        if (stk.size() > 0) return stk[stk.size()-1];
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_next();
        if (stk.size() > 1) return stk[stk.size()-2];
        return '0;
    endfunction

    function automatic logic [WIDTH-1:0] ref_src(input logic [2:0] ctl,
                                                 input logic [11:0] im,
                                                 input logic [WIDTH-1:0] alu,
                                                 input logic [WIDTH-1:0] md,
                                                 input logic [WIDTH-1:0] ind);
        case (ctl)
            3'd0:    return WIDTH'($signed(im));
            3'd1:    return WIDTH'(im[7:0]) << 8;
            3'd2:    return md;
            3'd3:    return alu;
            3'd4:    return ind;
            default: return '0;
        endcase
    endfunction

    task automatic model_apply(input logic r, input logic e, input logic [2:0] op,
                               input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        if (r) begin
            stk.delete();
            m_uf = 1'b0;
            m_of = 1'b0;
        end else if (e) begin
            case (op)
                3'd1: if (stk.size() < DEPTH) stk.push_back(s); else m_of = 1'b1;
                3'd2: if (stk.size() >= 2) begin
                          a = stk.pop_back();
                          b = stk.pop_back();
                          stk.push_back(s);
                      end else m_uf = 1'b1;
                3'd3: if (stk.size() >= 1) a = stk.pop_back(); else m_uf = 1'b1;
                3'd4: if (stk.size() >= 2) begin
                          a = stk.pop_back();
                          b = stk.pop_back();
                      end else m_uf = 1'b1;
                3'd5: if (stk.size() >= 2) begin
                          a = stk.pop_back();
                          b = stk.pop_back();
                          stk.push_back(a);
                          stk.push_back(b);
                      end else m_uf = 1'b1;
                default: ;
            endcase
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [EW-1:0] exp_q [$];
    int            checks;
    int            failures;

    initial begin
        checks   = 0;
        failures = 0;
    end

    // One expectation per presented op; compared shortly after the edge that
    // applies it.
    initial begin
        logic [EW-1:0] exp;
        logic [EW-1:0] got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {top, next, count, underflow, overflow};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL stack_state t=%0t got top=%h next=%h count=%0d uf=%b of=%b exp top=%h next=%h count=%0d uf=%b of=%b",
                             $time, got[EW-1 -: WIDTH], got[EW-WIDTH-1 -: WIDTH],
                             got[CW+1:2], got[1], got[0],
                             exp[EW-1 -: WIDTH], exp[EW-WIDTH-1 -: WIDTH],
                             exp[CW+1:2], exp[1], exp[0]);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input logic r, input logic e, input logic [2:0] op,
                         input logic [2:0] ctl, input logic [11:0] im,
                         input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] md,
                         input logic [WIDTH-1:0] ind);
        @(negedge clk);
        reset        = r;
        en           = e;
        stackOP      = op;
        stackControl = ctl;
        imm          = im;
        aluResult    = alu;
        memData      = md;
        inData       = ind;
        model_apply(r, e, op, ref_src(ctl, im, alu, md, ind));
        exp_q.push_back({m_top(), m_next(), CW'(stk.size()), m_uf, m_of});
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 3'd1, 3'd0, 12'h0, '0, '0, '0);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [2:0] ctl,
                         input logic [11:0] im, input logic [WIDTH-1:0] alu);
        drive(1'b0, 1'b1, op, ctl, im, alu, 16'hDEAD, 16'hC0DE);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        stackOP      = 3'd0;
        stackControl = 3'd0;
        imm          = '0;
        aluResult    = '0;
        memData      = '0;
        inData       = '0;
        m_uf         = 1'b0;
        m_of         = 1'b0;

        // Reset state, then sign-extended immediates.
        do_reset();
        do_op(3'd1, 3'd0, 12'h005, 16'h1111);
        do_op(3'd1, 3'd0, 12'hFFE, 16'h1111);

        // Binary op, then lui push.
        do_reset();
        do_op(3'd1, 3'd3, 12'h0, 16'h0007);
        do_op(3'd1, 3'd3, 12'h0, 16'h0003);
        do_op(3'd2, 3'd3, 12'h0, 16'h000A);
        do_op(3'd1, 3'd1, 12'h012, 16'h2222);

        // Push 1..5, swap, pop2, pops down to empty, then one underflow.
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(3'd1, 3'd3, 12'h0, WIDTH'(i));
        do_op(3'd5, 3'd0, 12'h0, '0);
        do_op(3'd4, 3'd0, 12'h0, '0);
        for (int i = 0; i < 4; i++) do_op(3'd3, 3'd0, 12'h0, '0);

        // Fill to DEPTH, overflow, drain through the deep entries.
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_op(3'd1, 3'd3, 12'h0, WIDTH'(16'h0100 + i));
        do_op(3'd1, 3'd3, 12'h0, 16'hBEEF);
        do_op(3'd3, 3'd0, 12'h0, '0);
        do_op(3'd1, 3'd3, 12'h0, 16'h0F0F);
        do_op(3'd3, 3'd0, 12'h0, '0);
        for (int i = 0; i < DEPTH - 2; i++) do_op(3'd3, 3'd0, 12'h0, '0);

        // Shortfalls at count==1, then en=0 with a memData push.
        do_reset();
        do_op(3'd1, 3'd3, 12'h0, 16'h0055);
        do_op(3'd5, 3'd0, 12'h0, '0);
        do_op(3'd2, 3'd3, 12'h0, 16'h9999);
        do_op(3'd4, 3'd0, 12'h0, '0);
        drive(1'b0, 1'b0, 3'd1, 3'd2, 12'h0, '0, 16'h1234, '0);

        // Both flags set with count=5, reset mid-sequence, push inData.
        do_reset();
        do_op(3'd3, 3'd0, 12'h0, '0);
        for (int i = 0; i <= DEPTH; i++) do_op(3'd1, 3'd3, 12'h0, WIDTH'(16'h0200 + i));
        for (int i = 0; i < DEPTH - 5; i++) do_op(3'd3, 3'd0, 12'h0, '0);
        do_reset();
        drive(1'b0, 1'b1, 3'd1, 3'd4, 12'h0, '0, '0, 16'h00AA);

        // Randomized phases alternating push-heavy and pop-heavy traffic.
        for (int p = 0; p < 8; p++) begin
            for (int n = 0; n < 80; n++) begin
                logic [2:0]       op;
                logic [WIDTH-1:0] alu;
                logic             e;
                logic             r;
                op = 3'($urandom_range(0, 7));
                if ((p % 2) == 0 && $urandom_range(0, 99) < 45) op = 3'd1;
                if ((p % 2) == 1 && $urandom_range(0, 99) < 30) op = 3'd3;
                alu = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom)
                                                  : WIDTH'(m_top() + m_next());
                e = ($urandom_range(0, 9) != 0);
                r = ($urandom_range(0, 199) == 0);
                drive(r, e, op, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)),
                      alu, WIDTH'($urandom), WIDTH'($urandom));
            end
        end

        // Idle one cycle so the last expectation is consumed.
        drive(1'b0, 1'b1, 3'd0, 3'd0, 12'h0, '0, '0, '0);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
